data_mem_io: RTL
================

Name: data_mem_io

Overview:
- Data-side responder for the 4-bit CPU's memory interface, driven by the program decoder's MEM_A, MEMW_LD and MEMR_LD.
- Holds the 13-word user data memory (addresses 0x0..0xC).
- Provides memory-mapped IOIN (0xD) with an input synchronizer and IOOUT (0xE) with a valid/ack handshake toward the external consumer.
- Returns read data in the same cycle so the CPU can load R0/R1 at the next clock edge.

Parameters:
- P_MEM, 4'hC, maximum address of user memory.
- P_IOIN, 4'hD, address of IOIN (memory-mapped I/O).
- P_IOOUT, 4'hE, address of IOOUT (memory-mapped I/O).
- P_SYNC, 2, IOIN synchronizer depth in flops (legal values 2..3).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous reset, active low.
- MEM_A  input  4  memory address from the decoder.
- MEMW_LD  input  1  write strobe; the write takes effect at the rising edge.
- MEMR_LD  input  1  read qualifier.
- MEM_WD  input  4  write data (ALU result, R0 or R1).
- MEM_RD  output  4  read data, combinational from state.
- IOIN  input  4  external input, asynchronous to CLK.
- IOOUT  output  4  registered output port.
- IOOUT_VLD  output  1  IOOUT holds data not yet acknowledged.
- IOOUT_ACK  input  1  consumer acknowledge, sampled at the rising edge.
- ERR_CLR  input  1  synchronous clear of the sticky flags.
- MEM_ERR  output  1  sticky flag: illegal access.
- IOOUT_OVR  output  1  sticky flag: IOOUT overrun.

Behaviour:
- Reset (RST_N=0, asynchronous): all 13 memory words, the sync flops, IOOUT, IOOUT_VLD, MEM_ERR and IOOUT_OVR clear to 0. This is held until RST_N deasserts.

Write (MEMW_LD=1 at the edge):
- MEM_A<=P_MEM: mem[MEM_A] <= MEM_WD.
- MEM_A==P_IOOUT: IOOUT <= MEM_WD and IOOUT_VLD <= 1.
- MEM_A==P_IOIN or 0xF: no state change; MEM_ERR <= 1.

Read (combinational, independent of MEMR_LD):
- MEM_RD = mem[MEM_A] for addresses <=P_MEM.
- MEM_RD = synchronized IOIN (last sync stage) at P_IOIN.
- MEM_RD = IOOUT register at P_IOOUT.
- MEM_RD = 4'h0 at 0xF.
- MEMR_LD=1 at 0xF sets MEM_ERR at the edge.

Simultaneous strobes and latency:
- MEMW_LD and MEMR_LD both 1: the write is performed and MEM_ERR <= 1.
- MEM_RD shows pre-edge (old) data in that cycle.
- Read-after-write latency is 1 cycle: a write at edge N is visible on MEM_RD after edge N.

IOIN synchronizer:
- P_SYNC-flop chain per bit, no reset glitch.
- A change on IOIN is visible on MEM_RD after P_SYNC rising edges.

IOOUT handshake:
- VLD=1 and ACK=1 at the edge with no write: VLD <= 0; IOOUT holds its value.
- Write to P_IOOUT while VLD=1 and ACK=0: data is overwritten, VLD stays 1, IOOUT_OVR <= 1.
- Write to P_IOOUT with ACK=1 in the same cycle: the old data counts as consumed. New data loads, VLD stays 1, no overrun.
- ACK while VLD=0: ignored.

Sticky flags:
- ERR_CLR=1 clears MEM_ERR and IOOUT_OVR at the edge.
- A new error event in the same cycle wins: the flag stays set.

Address decode:
- All 16 MEM_A values are decoded.
- Addresses 0xD..0xF never alias user memory.

Decomposition:
- Shared package prg_pkg holds:
  - address constants for MEM_MAX, IOIN and IOOUT, identical to those used by the decoder;
  - data width 4 and address width 4.
- One sub-module, io_sync: a parameterized P_SYNC-stage, 4-bit synchronizer with asynchronous active-low reset.
- The memory array, IOOUT handshake and flags stay in data_mem_io.

Test Plan:
- Reset, then write 4'h5 to 0x3 and 4'hA to 0xC; read both back. Require MEM_RD=5 then A, and 0x0 still reads 0.
- Hold IOIN=4'h9 and read 0xD each cycle. Require MEM_RD=0 for P_SYNC cycles, then 9, with MEM_ERR still 0.
- Write 4'h7 to 0xE. Require IOOUT=7 and VLD=1 after the edge. Pulse ACK one cycle and require VLD=0 with IOOUT still 7.
- Write 4'h1 then 4'h2 to 0xE with no ACK. Require IOOUT=2 and IOOUT_OVR=1. Repeat with ACK high during the second write and require OVR=0.
- Write 4'h3 to 0xD, then read 0xF. Require no state change, MEM_RD=0 and MEM_ERR=1. Pulse ERR_CLR and require MEM_ERR=0.
- Assert RST_N low mid-sequence with IOOUT_VLD=1 and memory loaded. Require all outputs and memory at 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prg_pkg.sv
// Shared constants for the 4-bit CPU: data/address widths and the memory map
// used by both the program decoder and the data-side responder.
package prg_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t MEM_MAX    = 4'hC;
  localparam addr_t IOIN_ADDR  = 4'hD;
  localparam addr_t IOOUT_ADDR = 4'hE;
  localparam addr_t NULL_ADDR  = 4'hF;
endpackage

// File: rtl/io_sync.sv
// Multi-flop synchronizer for the asynchronous IOIN bus; every bit has its own
// chain, and the last stage is the only one the rest of the design may use.
module io_sync
  import prg_pkg::*;
#(
  parameter int P_SYNC = 2,
  parameter int P_W    = DATA_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [P_W-1:0] i_d,
  output logic [P_W-1:0] o_q
);
  logic [P_W-1:0] r_sync [P_SYNC];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < P_SYNC; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < P_SYNC; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[P_SYNC-1];
endmodule

// File: rtl/data_mem_io.sv
// Data-side responder: user data memory, memory-mapped IOIN/IOOUT and sticky
// error flags. Read data is combinational so the CPU loads it at the next edge.
module data_mem_io
  import prg_pkg::*;
#(
  parameter addr_t P_MEM   = MEM_MAX,
  parameter addr_t P_IOIN  = IOIN_ADDR,
  parameter addr_t P_IOOUT = IOOUT_ADDR,
  parameter int    P_SYNC  = 2
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  addr_t MEM_A,
  input  logic  MEMW_LD,
  input  logic  MEMR_LD,
  input  data_t MEM_WD,
  output data_t MEM_RD,
  input  data_t IOIN,
  output data_t IOOUT,
  output logic  IOOUT_VLD,
  input  logic  IOOUT_ACK,
  input  logic  ERR_CLR,
  output logic  MEM_ERR,
  output logic  IOOUT_OVR
);
  data_t r_mem [0:P_MEM];
  data_t r_ioout;
  logic  r_vld;
  logic  r_mem_err;
  logic  r_ovr;
  data_t w_ioin_s;
  data_t w_rd;
  logic  w_wr_mem;
  logic  w_wr_out;
  logic  w_err_evt;
  logic  w_ovr_evt;

  io_sync #(.P_SYNC(P_SYNC), .P_W(DATA_W)) u_io_sync (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_d    (IOIN),
    .o_q    (w_ioin_s)
  );

  assign w_wr_mem = MEMW_LD && (MEM_A <= P_MEM);
  assign w_wr_out = MEMW_LD && (MEM_A == P_IOOUT);
  // Writes to IOIN/0xF, reads of 0xF, and both strobes at once are illegal.
  assign w_err_evt = (MEMW_LD && ((MEM_A == P_IOIN) || (MEM_A == NULL_ADDR)))
                   || (MEMR_LD && (MEM_A == NULL_ADDR))
                   || (MEMW_LD && MEMR_LD);
  // A same-cycle ACK means the old IOOUT value was consumed, so no overrun.
  assign w_ovr_evt = w_wr_out && r_vld && !IOOUT_ACK;

  always_comb begin
    w_rd = '0;
    if (MEM_A <= P_MEM)        w_rd = r_mem[MEM_A];
    else if (MEM_A == P_IOIN)  w_rd = w_ioin_s;
    else if (MEM_A == P_IOOUT) w_rd = r_ioout;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i <= int'(P_MEM); i++) r_mem[i] <= '0;
    end else if (w_wr_mem) begin
      r_mem[MEM_A] <= MEM_WD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ioout <= '0;
      r_vld   <= 1'b0;
    end else if (w_wr_out) begin
      r_ioout <= MEM_WD;
      r_vld   <= 1'b1;
    end else if (IOOUT_ACK) begin
      r_vld   <= 1'b0;
    end
  end

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mem_err <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_err_evt)    r_mem_err <= 1'b1;
      else if (ERR_CLR) r_mem_err <= 1'b0;
      if (w_ovr_evt)    r_ovr     <= 1'b1;
      else if (ERR_CLR) r_ovr     <= 1'b0;
    end
  end

  assign MEM_RD    = w_rd;
  assign IOOUT     = r_ioout;
  assign IOOUT_VLD = r_vld;
  assign MEM_ERR   = r_mem_err;
  assign IOOUT_OVR = r_ovr;
endmodule
